data_mem_responder: RTL and testbench

- Memory-side responder for the MEM stage data-memory interface (read/write enables, byte address, store data, load data).
- Replaces the zero-wait memory with a multi-cycle responder with configurable latency.
- Provides a stall handshake back to the pipeline, plus alignment and range error reporting.
- Sits between the MEM stage and the word array; the pipeline holds the instruction in MEM while `stall` is high.

---
 rtl/data_mem_responder_pkg.sv | 14 +
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_array.sv | 30 +++
 rtl/data_mem_responder.sv | 133 +++++++++++++
 tb/tb_data_mem_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package data_mem_responder_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] BASE_ADDR = 32'd1024;
    localparam int CNT_W = $clog2(16);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage data-memory bus: pipeline side is master, responder is slave.
interface data_mem_responder_if;
    import data_mem_responder_pkg::*;

    logic              readEn;
    logic              writeEn;
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] dataIn;
    logic [WORD_W-1:0] dataOut;
    logic              ready;
    logic              stall;
    logic              err;

    modport master (
        output readEn, writeEn, address, dataIn,
        input  dataOut, ready, stall, err
    );

    modport slave (
        input  readEn, writeEn, address, dataIn,
        output dataOut, ready, stall, err
    );

endinterface

// File: rtl/data_mem_array.sv
// Word array: synchronous write, asynchronous read, synchronous active-low clear of every word.
module data_mem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_clr_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    logic [WORD_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!i_clr_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: latches one request, answers LATENCY cycles later
// with a one-cycle ready strobe, stalls the pipeline meanwhile and flags bad requests.
//
// state | meaning
// IDLE  | no request outstanding; a request is accepted on the next edge
// WAIT  | request latched, counting down the remaining latency
// RESP  | ready/err/dataOut presented for exactly one cycle
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  s_bus
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_rd;
    logic              r_wr;
    logic [WORD_W-1:0] r_addr;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] r_dout;
    logic              r_ready;
    logic              r_err;

    logic              w_req;
    logic              w_in_idle;
    logic              w_sel_rd;
    logic              w_sel_wr;
    logic [WORD_W-1:0] w_sel_addr;
    logic [WORD_W-1:0] w_sel_data;
    logic [WORD_W-1:0] w_offset;
    logic [WORD_W-1:0] w_word;
    logic              w_bad;
    logic              w_enter_resp;
    logic              w_we;
    logic [ADDR_W-1:0] w_idx;
    logic [WORD_W-1:0] w_rdata;

    assign w_req     = s_bus.readEn | s_bus.writeEn;
    assign w_in_idle = (r_state == IDLE);

    // With LATENCY==1 the response is entered on the accepting edge, so decode the live inputs there.
    assign w_sel_rd   = w_in_idle ? s_bus.readEn  : r_rd;
    assign w_sel_wr   = w_in_idle ? s_bus.writeEn : r_wr;
    assign w_sel_addr = w_in_idle ? s_bus.address : r_addr;
    assign w_sel_data = w_in_idle ? s_bus.dataIn  : r_data;

    assign w_offset = w_sel_addr - BASE_ADDR;
    assign w_word   = w_offset >> 2;
    assign w_idx    = w_word[ADDR_W-1:0];

    // Below-base check also catches wrap-around of the unsigned subtraction.
    assign w_bad = (w_sel_addr[1:0] != 2'b00)
                 | (w_sel_addr < BASE_ADDR)
                 | (w_word >= WORD_W'(DEPTH))
                 | (w_sel_rd & w_sel_wr);

    assign w_enter_resp = (w_in_idle & w_req & (LATENCY == 1))
                        | ((r_state == WAIT) & (r_cnt == CNT_W'(1)));

    assign w_we = w_enter_resp & w_sel_wr & ~w_bad;

    data_mem_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .i_clr_n (rst),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (w_sel_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_dout  <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_rd    <= s_bus.readEn;
                        r_wr    <= s_bus.writeEn;
                        r_addr  <= s_bus.address;
                        r_data  <= s_bus.dataIn;
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_state <= (LATENCY == 1) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_enter_resp) begin
                r_ready <= 1'b1;
                r_err   <= w_bad;
                if (w_bad) begin
                    r_dout <= '0;
                end else if (w_sel_rd) begin
                    r_dout <= w_rdata;
                end
            end
        end
    end

    assign s_bus.stall   = (w_in_idle & w_req) | (r_state == WAIT);
    assign s_bus.ready   = r_ready;
    assign s_bus.err     = r_err;
    assign s_bus.dataOut = r_dout;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (LATENCY=1 and LATENCY=2) checked against a word-array model.
module tb_data_mem_responder;

    localparam int          DEPTH = 64;
    localparam int unsigned BASE  = 1024;

    logic clk;
    logic rst;

    data_mem_responder_if bus1 ();
    data_mem_responder_if bus2 ();

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut_l1 (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus1)
    );

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut_l2 (
        .clk   (clk),
        .rst   (rst),
        .s_bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cur    = 2;

    logic [31:0] ref_mem  [2][DEPTH];
    logic [31:0] ref_dout [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s (lat=%0d): observed=%0h expected=%0h", tag, cur, obs, exp);
        end
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
        if (cur == 1) begin
            bus1.readEn = rd; bus1.writeEn = wr; bus1.address = a; bus1.dataIn = d;
        end else begin
            bus2.readEn = rd; bus2.writeEn = wr; bus2.address = a; bus2.dataIn = d;
        end
    endtask

    task automatic sample(output logic rdy, output logic stl, output logic er, output logic [31:0] dout);
        if (cur == 1) begin
            rdy = bus1.ready; stl = bus1.stall; er = bus1.err; dout = bus1.dataOut;
        end else begin
            rdy = bus2.ready; stl = bus2.stall; er = bus2.err; dout = bus2.dataOut;
        end
    endtask

    function automatic bit ref_bad(input bit rd, input bit wr, input logic [31:0] a);
        longint unsigned ua;
        ua = a;
        if (rd && wr)                    return 1'b1;
        if (ua % 4 != 0)                 return 1'b1;
        if (ua < BASE)                   return 1'b1;
        if ((ua - BASE) / 4 >= DEPTH)    return 1'b1;
        return 1'b0;
    endfunction

    task automatic ref_reset();
        for (int m = 0; m < 2; m++) begin
            ref_dout[m] = '0;
            for (int i = 0; i < DEPTH; i++) ref_mem[m][i] = '0;
        end
    endtask

    task automatic check_quiet(input string tag);
        logic rdy, stl, er;
        logic [31:0] dout;
        for (int l = 1; l <= 2; l++) begin
            cur = l;
            sample(rdy, stl, er, dout);
            chk({tag, "_ready"}, 32'(rdy), 32'd0);
            chk({tag, "_stall"}, 32'(stl), 32'd0);
            chk({tag, "_err"},   32'(er),  32'd0);
            chk({tag, "_dout"},  dout,     ref_dout[l-1]);
        end
    endtask

    // Issues one request in the current IDLE cycle (called #1 after an edge) and returns #1 after the edge ending RESP.
    task automatic do_req(input int lat, input bit rd, input bit wr,
                          input logic [31:0] a, input logic [31:0] d, input bit churn);
        logic rdy, stl, er;
        logic [31:0] dout;
        bit got, bad;
        int m, idx;
        logic [31:0] exp_dout;

        cur = lat;
        m   = lat - 1;
        bad = ref_bad(rd, wr, a);
        exp_dout = ref_dout[m];
        if (bad) begin
            exp_dout = '0;
        end else begin
            idx = int'((a - BASE) / 4);
            if (wr) ref_mem[m][idx] = d;
            else    exp_dout = ref_mem[m][idx];
        end

        drive(rd, wr, a, d);
        @(negedge clk);
        sample(rdy, stl, er, dout);
        chk("req_stall", 32'(stl), 32'd1);
        chk("req_ready", 32'(rdy), 32'd0);
        @(posedge clk);

        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            #1;
            if (churn) drive(rd, wr, $urandom, $urandom);
            @(negedge clk);
            sample(rdy, stl, er, dout);
            if (rdy) begin
                got = 1'b1;
                chk("latency",    32'(k),   32'(lat));
                chk("resp_stall", 32'(stl), 32'd0);
                chk("resp_err",   32'(er),  32'(bad));
                chk("resp_dout",  dout,     exp_dout);
            end else begin
                chk("wait_stall", 32'(stl), 32'd1);
                @(posedge clk);
            end
        end
        chk("ready_seen", 32'(got), 32'd1);
        ref_dout[m] = exp_dout;
        drive(1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy, stl, er;
        logic [31:0] dout;
        logic [31:0] v;
        logic [31:0] a;
        bit rd, wr;
        int sel;

        rst = 1'b0;
        cur = 1; drive(1'b0, 1'b0, '0, '0);
        cur = 2; drive(1'b0, 1'b0, '0, '0);
        ref_reset();

        // reset then idle
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_quiet("rst");
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("idle");
        end
        @(posedge clk); #1;

        // write then reads, LATENCY=2
        do_req(2, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);

        // error cases, then confirm the stored word survived
        do_req(2, 1'b1, 1'b0, 32'd1030, 32'h0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        do_req(2, 1'b1, 1'b0, BASE + 4 * DEPTH, 32'h0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        do_req(2, 1'b1, 1'b1, 32'd1028, 32'h12345678, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);
        do_req(2, 1'b0, 1'b1, 32'd1000, 32'hCAFE0000, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

        // input churn during WAIT
        do_req(2, 1'b0, 1'b1, 32'd1032, 32'h11, 1'b1);
        do_req(2, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);

        // reset during WAIT discards the pending write
        cur = 2;
        drive(1'b0, 1'b1, 32'd1036, 32'h55);
        @(negedge clk);
        sample(rdy, stl, er, dout);
        chk("midrst_req_stall", 32'(stl), 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        ref_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_quiet("midrst");
        end
        @(posedge clk); #1;
        do_req(2, 1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
        do_req(2, 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0);

        // back-to-back write/read with LATENCY=1
        for (int i = 0; i < 6; i++) begin
            v = $urandom;
            do_req(1, 1'b0, 1'b1, 32'd1040, v, 1'b0);
            do_req(1, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
        end

        // randomized mix on both instances
        for (int i = 0; i < 80; i++) begin
            sel = $urandom_range(0, 9);
            rd  = 1'b0;
            wr  = 1'b0;
            if ($urandom_range(0, 1) == 0) rd = 1'b1; else wr = 1'b1;
            a = BASE + 4 * $urandom_range(0, 15);
            case (sel)
                7: a = a + $urandom_range(1, 3);
                8: a = (($urandom_range(0, 1) == 0) ? $urandom_range(0, BASE - 1)
                                                     : BASE + 4 * $urandom_range(DEPTH, DEPTH + 8));
                9: begin rd = 1'b1; wr = 1'b1; end
                default: ;
            endcase
            do_req($urandom_range(1, 2), rd, wr, a, $urandom, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        check_quiet("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
